// File: rtl/div_issue_ctrl.sv
// Execute-stage requester for the iterative divider: accepts DIV/REM ops, resolves
// RISC-V special cases and single-entry cache hits locally, otherwise runs the divider.
module div_issue_ctrl #(
    parameter int XLEN     = 32,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            div_start,
    output logic            div_is_signed,
    output logic            div_is_rem,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rem,
    input  logic            div_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            stall
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, RESP} state_t;
    state_t state, state_nxt;

    logic            cache_valid, cache_signed;
    logic [XLEN-1:0] cache_rs1, cache_rs2, cache_quot, cache_rem;

    logic            accept, op_signed, op_rem;
    logic            div_by_zero, overflow, cache_hit, local_hit, div_busy;
    logic [XLEN-1:0] local_data;

    always_comb begin
        in_ready    = (state == IDLE) && !flush && !reset;
        accept      = in_valid && in_ready;
        op_signed   = ~in_op[0];
        op_rem      = in_op[1];
        div_by_zero = (in_rs2 == '0);
        overflow    = op_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
        cache_hit   = CACHE_EN && cache_valid && (cache_rs1 == in_rs1) &&
                      (cache_rs2 == in_rs2) && (cache_signed == op_signed);
        local_hit   = div_by_zero || overflow || cache_hit;
        div_busy    = (state == WAIT) || (state == DRAIN);
        out_valid   = (state == RESP);
        stall       = (state != IDLE);
        if (div_by_zero)   local_data = op_rem ? in_rs1 : '1;
        else if (overflow) local_data = op_rem ? '0 : in_rs1;
        else               local_data = op_rem ? cache_rem : cache_quot;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = local_hit ? RESP : WAIT;
            // A flush cannot abort the divider, so a killed op drains until done.
            WAIT:    if (div_done) state_nxt = flush ? IDLE : RESP;
                     else if (flush) state_nxt = DRAIN;
            DRAIN:   if (div_done) state_nxt = IDLE;
            RESP:    if (flush || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_start     <= 1'b0;
            div_is_signed <= 1'b0;
            div_is_rem    <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            out_data      <= '0;
            out_rd        <= '0;
            cache_valid   <= 1'b0;
            cache_signed  <= 1'b0;
            cache_rs1     <= '0;
            cache_rs2     <= '0;
            cache_quot    <= '0;
            cache_rem     <= '0;
        end else begin
            div_start <= 1'b0;
            if (accept) begin
                out_rd <= in_rd;
                if (local_hit) begin
                    out_data <= local_data;
                end else begin
                    div_start     <= 1'b1;
                    div_is_signed <= op_signed;
                    div_is_rem    <= op_rem;
                    div_dividend  <= in_rs1;
                    div_divisor   <= in_rs2;
                end
            end
            // Drained results are still correct for their operands, so they fill the cache too.
            if (div_done && div_busy) begin
                cache_valid  <= 1'b1;
                cache_signed <= div_is_signed;
                cache_rs1    <= div_dividend;
                cache_rs2    <= div_divisor;
                cache_quot   <= div_quot;
                cache_rem    <= div_rem;
                if (state == WAIT) out_data <= div_is_rem ? div_rem : div_quot;
            end
        end
    end
endmodule
